// File: rtl/biriscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// biriscv_mem_pkg : shared types and range check for the memory arbiter
// Revision: 1.0
// ============================================================================
package biriscv_mem_pkg;

    typedef enum logic {
        MST_INSTR = 1'b0,
        MST_DATA  = 1'b1
    } master_e;

    typedef enum logic [2:0] {
        RESP_IDLE  = 3'd0,
        RESP_I     = 3'd1,
        RESP_D     = 3'd2,
        RESP_I_ERR = 3'd3,
        RESP_D_ERR = 3'd4
    } resp_state_e;

    // Byte address is in range when every bit above the word-address field is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] hi;
        hi = addr >> (aw + 2);
        return (hi == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/biriscv_rr_arb2.sv
`default_nettype none
// ============================================================================
// biriscv_rr_arb2 : two-requester arbiter, round-robin or fixed priority
// Revision: 1.0
// ============================================================================
module biriscv_rr_arb2
    import biriscv_mem_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    master_e r_last;

    // Bit 0 is the instruction port, bit 1 the data port.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = ((ARB_MODE == 1) || (r_last == MST_INSTR)) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= MST_INSTR;
        end else if (o_gnt[1]) begin
            r_last <= MST_DATA;
        end else if (o_gnt[0]) begin
            r_last <= MST_INSTR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/biriscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// biriscv_mem_arbiter : instruction/data arbiter in front of single-port RAM
// Revision: 1.0
// ============================================================================
module biriscv_mem_arbiter
    import biriscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    input  logic [31:0]             instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_err_o,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [31:0]             data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,
    output logic                    ram_req_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    logic [1:0]  w_arb_gnt;
    logic [1:0]  w_gnt;
    logic        w_instr_ok;
    logic        w_data_ok;
    logic        w_unused_lsbs;
    resp_state_e r_state;
    logic        r_resp_we;

    biriscv_rr_arb2 #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_req  ({data_req_i, instr_req_i}),
        .o_gnt  (w_arb_gnt)
    );

    // Grants are combinational, so they are masked to keep every output low during reset.
    assign w_gnt         = w_arb_gnt & {2{rst_ni}};
    assign w_instr_ok    = addr_in_range(instr_addr_i, ADDR_WIDTH);
    assign w_data_ok     = addr_in_range(data_addr_i, ADDR_WIDTH);
    assign w_unused_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    assign instr_gnt_o = w_gnt[0];
    assign data_gnt_o  = w_gnt[1];

    assign ram_req_o   = (w_gnt[0] & w_instr_ok) | (w_gnt[1] & w_data_ok);
    assign ram_we_o    = w_gnt[1] & w_data_ok & data_we_i;
    assign ram_wstrb_o = (w_gnt[1] & w_data_ok & data_we_i) ? data_be_i : '0;
    assign ram_wdata_o = w_gnt[1] ? data_wdata_i : '0;
    assign ram_addr_o  = w_gnt[1] ? data_addr_i[ADDR_WIDTH+1:2] :
                         w_gnt[0] ? instr_addr_i[ADDR_WIDTH+1:2] : '0;

    // Each response state lives exactly one cycle; the next one is chosen by this cycle's grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= RESP_IDLE;
            r_resp_we <= 1'b0;
        end else begin
            r_resp_we <= w_gnt[1] & data_we_i;
            if (w_gnt[1]) begin
                r_state <= w_data_ok ? RESP_D : RESP_D_ERR;
            end else if (w_gnt[0]) begin
                r_state <= w_instr_ok ? RESP_I : RESP_I_ERR;
            end else begin
                r_state <= RESP_IDLE;
            end
        end
    end

    assign instr_rvalid_o = (r_state == RESP_I) || (r_state == RESP_I_ERR);
    assign instr_err_o    = (r_state == RESP_I_ERR);
    assign instr_rdata_o  = (r_state == RESP_I) ? ram_rdata_i : '0;

    assign data_rvalid_o  = (r_state == RESP_D) || (r_state == RESP_D_ERR);
    assign data_err_o     = (r_state == RESP_D_ERR);
    assign data_rdata_o   = ((r_state == RESP_D) && !r_resp_we) ? ram_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_biriscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_biriscv_mem_arbiter : directed self-checking bench for biriscv_mem_arbiter
// Revision: 1.0
// ============================================================================
module tb_biriscv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] ram_rdata;

    logic        instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_rdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;
    logic        ram_req, ram_we;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;

    logic        fp_instr_gnt, fp_instr_rvalid, fp_instr_err;
    logic [31:0] fp_instr_rdata;
    logic        fp_data_gnt, fp_data_rvalid, fp_data_err;
    logic [31:0] fp_data_rdata;
    logic        fp_ram_req, fp_ram_we;
    logic [19:0] fp_ram_addr;
    logic [31:0] fp_ram_wdata;
    logic [3:0]  fp_ram_wstrb;

    logic [31:0] mem [0:255];
    int          passed;
    int          total;

    biriscv_mem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .ARB_MODE(0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata), .data_err_o(data_err),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_wstrb_o(ram_wstrb), .ram_rdata_i(ram_rdata)
    );

    biriscv_mem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .ARB_MODE(1)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(fp_instr_gnt),
        .instr_rvalid_o(fp_instr_rvalid), .instr_rdata_o(fp_instr_rdata), .instr_err_o(fp_instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(fp_data_gnt), .data_rvalid_o(fp_data_rvalid),
        .data_rdata_o(fp_data_rdata), .data_err_o(fp_data_err),
        .ram_req_o(fp_ram_req), .ram_we_o(fp_ram_we), .ram_addr_o(fp_ram_addr), .ram_wdata_o(fp_ram_wdata),
        .ram_wstrb_o(fp_ram_wstrb), .ram_rdata_i(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model driven by the round-robin instance only.
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wstrb[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    task automatic test_reset();
        #3;
        instr_req = 1'b1;
        data_req  = 1'b1;
        #1;
        total++; if (instr_gnt !== 1'b0) $display("FAIL reset_instr_gnt got %b exp 0", instr_gnt); else passed++;
        total++; if (data_gnt !== 1'b0) $display("FAIL reset_data_gnt got %b exp 0", data_gnt); else passed++;
        total++; if (ram_req !== 1'b0) $display("FAIL reset_ram_req got %b exp 0", ram_req); else passed++;
        total++; if (instr_rvalid !== 1'b0) $display("FAIL reset_instr_rvalid got %b exp 0", instr_rvalid); else passed++;
        total++; if (data_rvalid !== 1'b0) $display("FAIL reset_data_rvalid got %b exp 0", data_rvalid); else passed++;
        @(posedge clk); #1;
        instr_req = 1'b0;
        data_req  = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_instr_read();
        instr_req  = 1'b1;
        instr_addr = 32'h10;
        #1;
        total++; if (instr_gnt !== 1'b1) $display("FAIL ird_gnt got %b exp 1", instr_gnt); else passed++;
        total++; if (ram_req !== 1'b1) $display("FAIL ird_ram_req got %b exp 1", ram_req); else passed++;
        total++; if (ram_addr !== 20'h4) $display("FAIL ird_ram_addr got %h exp 4", ram_addr); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL ird_ram_we got %b exp 0", ram_we); else passed++;
        total++; if (ram_wstrb !== 4'h0) $display("FAIL ird_wstrb got %h exp 0", ram_wstrb); else passed++;
        @(posedge clk); #1;
        instr_req = 1'b0;
        total++; if (instr_rvalid !== 1'b1) $display("FAIL ird_rvalid got %b exp 1", instr_rvalid); else passed++;
        total++; if (instr_rdata !== 32'hDEADBEEF) $display("FAIL ird_rdata got %h exp deadbeef", instr_rdata); else passed++;
        total++; if (instr_err !== 1'b0) $display("FAIL ird_err got %b exp 0", instr_err); else passed++;
        total++; if (data_rvalid !== 1'b0) $display("FAIL ird_data_rvalid got %b exp 0", data_rvalid); else passed++;
    endtask

    task automatic test_data_write();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'b0011;
        data_addr  = 32'h20;
        data_wdata = 32'h12345678;
        #1;
        total++; if (data_gnt !== 1'b1) $display("FAIL dwr_gnt got %b exp 1", data_gnt); else passed++;
        total++; if (ram_req !== 1'b1) $display("FAIL dwr_ram_req got %b exp 1", ram_req); else passed++;
        total++; if (ram_we !== 1'b1) $display("FAIL dwr_ram_we got %b exp 1", ram_we); else passed++;
        total++; if (ram_addr !== 20'h8) $display("FAIL dwr_ram_addr got %h exp 8", ram_addr); else passed++;
        total++; if (ram_wstrb !== 4'b0011) $display("FAIL dwr_wstrb got %b exp 0011", ram_wstrb); else passed++;
        total++; if (ram_wdata !== 32'h12345678) $display("FAIL dwr_wdata got %h exp 12345678", ram_wdata); else passed++;
        @(posedge clk); #1;
        data_req = 1'b0;
        data_we  = 1'b0;
        total++; if (data_rvalid !== 1'b1) $display("FAIL dwr_rvalid got %b exp 1", data_rvalid); else passed++;
        total++; if (data_rdata !== 32'h0) $display("FAIL dwr_rdata got %h exp 0", data_rdata); else passed++;
        total++; if (data_err !== 1'b0) $display("FAIL dwr_err got %b exp 0", data_err); else passed++;
        total++; if (mem[8] !== 32'h00005678) $display("FAIL dwr_mem got %h exp 00005678", mem[8]); else passed++;
    endtask

    task automatic test_round_robin();
        logic exp_d;
        rst_n = 1'b0;
        #1;
        rst_n      = 1'b1;
        instr_req  = 1'b1;
        instr_addr = 32'h10;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 32'h20;
        for (int i = 0; i < 6; i++) begin
            exp_d = (i % 2 == 0);
            #1;
            total++; if (data_gnt !== exp_d) $display("FAIL rr_data_gnt[%0d] got %b exp %b", i, data_gnt, exp_d); else passed++;
            total++; if (instr_gnt !== !exp_d) $display("FAIL rr_instr_gnt[%0d] got %b exp %b", i, instr_gnt, !exp_d); else passed++;
            @(posedge clk); #1;
            total++; if (data_rvalid !== exp_d) $display("FAIL rr_data_rvalid[%0d] got %b exp %b", i, data_rvalid, exp_d); else passed++;
            total++; if (instr_rvalid !== !exp_d) $display("FAIL rr_instr_rvalid[%0d] got %b exp %b", i, instr_rvalid, !exp_d); else passed++;
            if (exp_d) begin
                total++; if (data_rdata !== 32'h00005678) $display("FAIL rr_data_rdata[%0d] got %h exp 00005678", i, data_rdata); else passed++;
            end else begin
                total++; if (instr_rdata !== 32'hDEADBEEF) $display("FAIL rr_instr_rdata[%0d] got %h exp deadbeef", i, instr_rdata); else passed++;
            end
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_priority();
        instr_req = 1'b1;
        data_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (fp_data_gnt !== 1'b1) $display("FAIL fp_data_gnt[%0d] got %b exp 1", i, fp_data_gnt); else passed++;
            total++; if (fp_instr_gnt !== 1'b0) $display("FAIL fp_instr_gnt[%0d] got %b exp 0", i, fp_instr_gnt); else passed++;
            @(posedge clk); #1;
        end
        data_req = 1'b0;
        #1;
        total++; if (fp_instr_gnt !== 1'b1) $display("FAIL fp_instr_gnt_alone got %b exp 1", fp_instr_gnt); else passed++;
        @(posedge clk); #1;
        instr_req = 1'b0;
        total++; if (fp_instr_rvalid !== 1'b1) $display("FAIL fp_instr_rvalid got %b exp 1", fp_instr_rvalid); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h0040_0000;
        #1;
        total++; if (data_gnt !== 1'b1) $display("FAIL oor_data_gnt got %b exp 1", data_gnt); else passed++;
        total++; if (ram_req !== 1'b0) $display("FAIL oor_data_ram_req got %b exp 0", ram_req); else passed++;
        @(posedge clk); #1;
        data_req   = 1'b0;
        instr_req  = 1'b1;
        instr_addr = 32'h8000_0000;
        total++; if (data_rvalid !== 1'b1) $display("FAIL oor_data_rvalid got %b exp 1", data_rvalid); else passed++;
        total++; if (data_err !== 1'b1) $display("FAIL oor_data_err got %b exp 1", data_err); else passed++;
        total++; if (data_rdata !== 32'h0) $display("FAIL oor_data_rdata got %h exp 0", data_rdata); else passed++;
        #1;
        total++; if (instr_gnt !== 1'b1) $display("FAIL oor_instr_gnt got %b exp 1", instr_gnt); else passed++;
        total++; if (ram_req !== 1'b0) $display("FAIL oor_instr_ram_req got %b exp 0", ram_req); else passed++;
        @(posedge clk); #1;
        instr_req = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h003F_FFFC;
        total++; if (instr_rvalid !== 1'b1) $display("FAIL oor_instr_rvalid got %b exp 1", instr_rvalid); else passed++;
        total++; if (instr_err !== 1'b1) $display("FAIL oor_instr_err got %b exp 1", instr_err); else passed++;
        total++; if (instr_rdata !== 32'h0) $display("FAIL oor_instr_rdata got %h exp 0", instr_rdata); else passed++;
        #1;
        total++; if (ram_req !== 1'b1) $display("FAIL edge_ram_req got %b exp 1", ram_req); else passed++;
        total++; if (ram_addr !== 20'hFFFFF) $display("FAIL edge_ram_addr got %h exp fffff", ram_addr); else passed++;
        @(posedge clk); #1;
        data_req = 1'b0;
        total++; if (data_err !== 1'b0) $display("FAIL edge_data_err got %b exp 0", data_err); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_pulse();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h20;
        #1;
        total++; if (data_gnt !== 1'b1) $display("FAIL rp_first_gnt got %b exp 1", data_gnt); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (data_rvalid !== 1'b0) $display("FAIL rp_dropped_rvalid got %b exp 0", data_rvalid); else passed++;
        total++; if (data_gnt !== 1'b0) $display("FAIL rp_gnt_in_reset got %b exp 0", data_gnt); else passed++;
        @(posedge clk); #1;
        total++; if (data_rvalid !== 1'b0) $display("FAIL rp_rvalid_after got %b exp 0", data_rvalid); else passed++;
        total++; if (instr_rvalid !== 1'b0) $display("FAIL rp_instr_rvalid got %b exp 0", instr_rvalid); else passed++;
        rst_n      = 1'b1;
        instr_req  = 1'b1;
        instr_addr = 32'h10;
        #1;
        total++; if (data_gnt !== 1'b1) $display("FAIL rp_post_data_gnt got %b exp 1", data_gnt); else passed++;
        total++; if (instr_gnt !== 1'b0) $display("FAIL rp_post_instr_gnt got %b exp 0", instr_gnt); else passed++;
        @(posedge clk); #1;
        instr_req = 1'b0;
        data_req  = 1'b0;
        total++; if (data_rvalid !== 1'b1) $display("FAIL rp_post_rvalid got %b exp 1", data_rvalid); else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst_n      = 1'b0;
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        ram_rdata  = 32'h0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[4] = 32'hDEADBEEF;

        test_reset();
        test_instr_read();
        test_data_write();
        test_round_robin();
        test_fixed_priority();
        test_out_of_range();
        test_reset_pulse();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
